// File: rtl/sat_addsub_pipe_if.sv
// ---------------------------------------------------------------------------
// sat_addsub_pipe_if
// Groups the operand-side and result-side handshake buses of sat_addsub_pipe.
//
// Signals:
//   in_valid / in_ready   operand handshake (in_ready driven by the block)
//   a, b                  signed WIDTH-bit operands
//   op                    00 a+b, 01 a-b, 10 acc+b, 11 acc-b
//   out_valid / out_ready result handshake (out_ready driven by the consumer)
//   sum                   saturated WIDTH-bit result
//   pos_ovfl / neg_ovfl   result was clamped to max positive / min negative
//   zero                  sum == 0
//
// Modports:
//   master  operand source + result consumer side
//   slave   the arithmetic block
// ---------------------------------------------------------------------------
interface sat_addsub_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             pos_ovfl;
    logic             neg_ovfl;
    logic             zero;

    modport master (
        output in_valid,
        output a,
        output b,
        output op,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  sum,
        input  pos_ovfl,
        input  neg_ovfl,
        input  zero
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  op,
        input  out_ready,
        output in_ready,
        output out_valid,
        output sum,
        output pos_ovfl,
        output neg_ovfl,
        output zero
    );
endinterface

// File: rtl/sat_addsub_pipe.sv
// ---------------------------------------------------------------------------
// sat_addsub_pipe
// Two-stage pipelined saturating signed adder/subtractor with an internal
// saturating accumulator and sticky overflow flags.
//
// Stage 1 selects the operands (a or acc, b or ~b), adds the low half and
// registers the low sum, its carry and the upper operand halves.
// Stage 2 finishes the upper half, detects overflow on the effective operands
// and writes the saturated result into the output register.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   bus (slave)   in_valid/in_ready/a/b/op, out_valid/out_ready/sum,
//                 pos_ovfl/neg_ovfl/zero
//   acc           accumulator value
//   acc_clr       synchronous accumulator clear (beats a same-cycle load)
//   sticky_pos    sticky positive-overflow flag
//   sticky_neg    sticky negative-overflow flag
//   sticky_clr    clears both sticky flags (a same-cycle set beats it)
// ---------------------------------------------------------------------------
module sat_addsub_pipe #(
    parameter int WIDTH = 16,
    parameter int LO_W  = WIDTH / 2
) (
    input  logic             clk,
    input  logic             rst,
    sat_addsub_pipe_if.slave bus,
    output logic [WIDTH-1:0] acc,
    input  logic             acc_clr,
    output logic             sticky_pos,
    input  logic             sticky_clr,
    output logic             sticky_neg
);
    localparam int HI_W = WIDTH - LO_W;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic             s1_valid_reg;
    logic             s1_acc_op_reg;
    logic [LO_W-1:0]  s1_lo_sum_reg;
    logic             s1_carry_reg;
    logic [HI_W-1:0]  s1_a_hi_reg;
    logic [HI_W-1:0]  s1_b_hi_reg;

    logic             out_valid_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             pos_reg;
    logic             neg_reg;
    logic             zero_reg;

    logic [WIDTH-1:0] acc_reg;
    logic             sticky_pos_reg;
    logic             sticky_neg_reg;

    // -----------------------------------------------------------------------
    // Handshake control
    // -----------------------------------------------------------------------
    logic stall;
    logic acc_hazard;
    logic in_ready_int;
    logic in_fire;
    logic out_load;

    // A full output register that is not being drained freezes everything.
    assign stall = out_valid_reg & ~bus.out_ready;

    // Stage 2 is combinational into the output register, so an acc op sitting
    // in stage 1 is the only one whose result has not reached acc yet. Holding
    // a following acc op back one cycle lets it read the updated acc.
    assign acc_hazard   = bus.in_valid & bus.op[1] & s1_valid_reg & s1_acc_op_reg;
    assign in_ready_int = ~stall & ~acc_hazard;
    assign in_fire      = bus.in_valid & in_ready_int;
    assign out_load     = s1_valid_reg & ~stall;

    // -----------------------------------------------------------------------
    // Stage 1: operand selection and low-half add
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] a_sel;
    logic [LO_W:0]    lo_ext;

    // Subtraction is a + ~b + 1; the +1 rides in as the low-half carry-in.
    assign b_eff  = bus.op[0] ? ~bus.b : bus.b;
    assign a_sel  = bus.op[1] ? acc_reg : bus.a;
    assign lo_ext = {1'b0, a_sel[LO_W-1:0]}
                  + {1'b0, b_eff[LO_W-1:0]}
                  + {{LO_W{1'b0}}, bus.op[0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg  <= 1'b0;
            s1_acc_op_reg <= 1'b0;
            s1_lo_sum_reg <= '0;
            s1_carry_reg  <= 1'b0;
            s1_a_hi_reg   <= '0;
            s1_b_hi_reg   <= '0;
        end else if (!stall) begin
            s1_valid_reg <= in_fire;
            if (in_fire) begin
                s1_acc_op_reg <= bus.op[1];
                s1_lo_sum_reg <= lo_ext[LO_W-1:0];
                s1_carry_reg  <= lo_ext[LO_W];
                s1_a_hi_reg   <= a_sel[WIDTH-1:LO_W];
                s1_b_hi_reg   <= b_eff[WIDTH-1:LO_W];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stage 2: upper-half add, overflow detection, saturation
    // -----------------------------------------------------------------------
    logic [HI_W-1:0]  hi_raw;
    logic [WIDTH-1:0] raw;
    logic             pos_det;
    logic             neg_det;
    logic [WIDTH-1:0] sat_sum;
    logic             zero_det;

    assign hi_raw = s1_a_hi_reg + s1_b_hi_reg + {{(HI_W-1){1'b0}}, s1_carry_reg};
    assign raw    = {hi_raw, s1_lo_sum_reg};

    // Overflow only when both effective operands share a sign and the result
    // sign differs. Using the inverted b makes subtraction clamp correctly.
    assign pos_det = ~s1_a_hi_reg[HI_W-1] & ~s1_b_hi_reg[HI_W-1] &  hi_raw[HI_W-1];
    assign neg_det =  s1_a_hi_reg[HI_W-1] &  s1_b_hi_reg[HI_W-1] & ~hi_raw[HI_W-1];

    // Per-bit clamp: max positive is 0 then ones, min negative is 1 then zeros.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_sat
            localparam logic MAX_BIT = 1'(gi != WIDTH - 1);
            assign sat_sum[gi] = pos_det ? MAX_BIT
                               : neg_det ? ~MAX_BIT
                               : raw[gi];
        end
    endgenerate

    assign zero_det = (sat_sum == '0);

    // -----------------------------------------------------------------------
    // Output register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            sum_reg       <= '0;
            pos_reg       <= 1'b0;
            neg_reg       <= 1'b0;
            zero_reg      <= 1'b1;
        end else if (!stall) begin
            out_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                sum_reg  <= sat_sum;
                pos_reg  <= pos_det;
                neg_reg  <= neg_det;
                zero_reg <= zero_det;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Accumulator: loads the saturated result of an acc op when it is written
    // to the output register. An acc op already in stage 1 captured its
    // operand earlier, so a clear only affects the register itself.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg <= '0;
        end else if (acc_clr) begin
            acc_reg <= '0;
        end else if (out_load && s1_acc_op_reg) begin
            acc_reg <= sat_sum;
        end
    end

    // -----------------------------------------------------------------------
    // Sticky overflow flags: a new overflow in the same cycle beats the clear.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_pos_reg <= 1'b0;
            sticky_neg_reg <= 1'b0;
        end else begin
            sticky_pos_reg <= (out_load & pos_det) | (sticky_pos_reg & ~sticky_clr);
            sticky_neg_reg <= (out_load & neg_det) | (sticky_neg_reg & ~sticky_clr);
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = out_valid_reg;
    assign bus.sum       = sum_reg;
    assign bus.pos_ovfl  = pos_reg;
    assign bus.neg_ovfl  = neg_reg;
    assign bus.zero      = zero_reg;
    assign acc           = acc_reg;
    assign sticky_pos    = sticky_pos_reg;
    assign sticky_neg    = sticky_neg_reg;

endmodule

// File: tb/tb_sat_addsub_pipe.sv
// ---------------------------------------------------------------------------
// tb_sat_addsub_pipe
// Directed self-checking bench for sat_addsub_pipe (WIDTH=16 and WIDTH=8).
// Inputs are driven 1 ns after the rising edge; outputs are sampled 2 ns
// after the rising edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sat_addsub_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic acc_clr = 1'b0;
    logic sticky_clr = 1'b0;

    logic [15:0] acc16;
    logic        sticky_pos16;
    logic        sticky_neg16;
    logic [7:0]  acc8;
    logic        sticky_pos8;
    logic        sticky_neg8;

    int checks = 0;
    int errors = 0;

    logic fire_in;
    logic fire_out;
    logic prev_fire;

    sat_addsub_pipe_if #(.WIDTH(16)) if16 ();
    sat_addsub_pipe_if #(.WIDTH(8))  if8 ();

    sat_addsub_pipe #(.WIDTH(16)) u16 (
        .clk        (clk),
        .rst        (rst),
        .bus        (if16),
        .acc        (acc16),
        .acc_clr    (acc_clr),
        .sticky_pos (sticky_pos16),
        .sticky_clr (sticky_clr),
        .sticky_neg (sticky_neg16)
    );

    sat_addsub_pipe #(.WIDTH(8)) u8 (
        .clk        (clk),
        .rst        (rst),
        .bus        (if8),
        .acc        (acc8),
        .acc_clr    (1'b0),
        .sticky_pos (sticky_pos8),
        .sticky_clr (1'b0),
        .sticky_neg (sticky_neg8)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One isolated transaction on the 16-bit instance with out_ready=1.
    task automatic run_one(input string tag, input logic [1:0] op,
                           input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] es, input logic ep,
                           input logic en, input logic ez);
        if16.in_valid = 1'b1;
        if16.op = op;
        if16.a  = a;
        if16.b  = b;
        #1;
        chk({tag, "_in_ready"}, 32'(if16.in_ready), 32'd1);
        step();
        if16.in_valid = 1'b0;
        #1;
        chk({tag, "_lat1_valid"}, 32'(if16.out_valid), 32'd0);
        step();
        #1;
        chk({tag, "_valid"}, 32'(if16.out_valid), 32'd1);
        chk({tag, "_sum"},   32'(if16.sum),       32'(es));
        chk({tag, "_pos"},   32'(if16.pos_ovfl),  32'(ep));
        chk({tag, "_neg"},   32'(if16.neg_ovfl),  32'(en));
        chk({tag, "_zero"},  32'(if16.zero),      32'(ez));
        $display("txn %s op=%0d a=0x%04h b=0x%04h sum=0x%04h pos=%0b neg=%0b zero=%0b",
                 tag, op, a, b, if16.sum, if16.pos_ovfl, if16.neg_ovfl, if16.zero);
    endtask

    logic [15:0] bp_a   [4] = '{16'h0010, 16'h0020, 16'h0030, 16'h0040};
    logic [15:0] bp_b   [4] = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
    logic [15:0] bp_exp [4] = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
    logic [15:0] ac_exp [3] = '{16'h4000, 16'h7FFF, 16'h7FFF};
    logic        ac_pos [3] = '{1'b0, 1'b1, 1'b1};

    initial begin
        int idx;
        int oidx;
        int dups;

        if16.in_valid = 1'b0; if16.a = '0; if16.b = '0; if16.op = 2'b00; if16.out_ready = 1'b1;
        if8.in_valid  = 1'b0; if8.a  = '0; if8.b  = '0; if8.op  = 2'b00; if8.out_ready  = 1'b1;

        // ---------------- reset state ----------------
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rst_out_valid",  32'(if16.out_valid), 32'd0);
        chk("rst_sum",        32'(if16.sum),       32'd0);
        chk("rst_zero",       32'(if16.zero),      32'd1);
        chk("rst_pos",        32'(if16.pos_ovfl),  32'd0);
        chk("rst_neg",        32'(if16.neg_ovfl),  32'd0);
        chk("rst_acc",        32'(acc16),          32'd0);
        chk("rst_sticky_pos", 32'(sticky_pos16),   32'd0);
        chk("rst_sticky_neg", 32'(sticky_neg16),   32'd0);
        chk("rst_in_ready",   32'(if16.in_ready),  32'd1);
        $display("txn reset done");

        // ---------------- single ops ----------------
        run_one("add_pos_sat", 2'b00, 16'h7FFF, 16'h0001, 16'h7FFF, 1'b1, 1'b0, 1'b0);
        chk("sticky_pos_set", 32'(sticky_pos16), 32'd1);
        step();
        run_one("sub_neg_sat", 2'b01, 16'h8000, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0);
        chk("sticky_neg_set", 32'(sticky_neg16), 32'd1);
        step();
        run_one("sub_pos_sat", 2'b01, 16'h7FFF, 16'hFFFF, 16'h7FFF, 1'b1, 1'b0, 1'b0);
        step();
        run_one("sub_zero", 2'b01, 16'h0005, 16'h0005, 16'h0000, 1'b0, 1'b0, 1'b1);
        step();
        run_one("add_plain", 2'b00, 16'h1234, 16'h1111, 16'h2345, 1'b0, 1'b0, 1'b0);
        step();

        sticky_clr = 1'b1;
        step();
        sticky_clr = 1'b0;
        #1;
        chk("sticky_clr_pos", 32'(sticky_pos16), 32'd0);
        chk("sticky_clr_neg", 32'(sticky_neg16), 32'd0);
        $display("txn sticky_clr pos=%0b neg=%0b", sticky_pos16, sticky_neg16);

        // ---------------- backpressure ----------------
        idx = 0; oidx = 0; dups = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if16.out_ready = !(cyc >= 2 && cyc < 5);
            if16.in_valid  = (idx < 4);
            if16.op        = 2'b00;
            if (idx < 4) begin
                if16.a = bp_a[idx];
                if16.b = bp_b[idx];
            end
            #1;
            if (cyc >= 2 && cyc < 5) begin
                chk("bp_in_ready_low", 32'(if16.in_ready),  32'd0);
                chk("bp_hold_valid",   32'(if16.out_valid), 32'd1);
                chk("bp_hold_sum",     32'(if16.sum),       32'h0011);
            end
            fire_in  = if16.in_valid & if16.in_ready;
            fire_out = if16.out_valid & if16.out_ready;
            if (fire_out) begin
                if (oidx < 4) chk("bp_order_sum", 32'(if16.sum), 32'(bp_exp[oidx]));
                else dups++;
                $display("txn bp_out idx=%0d sum=0x%04h", oidx, if16.sum);
                oidx++;
            end
            step();
            if (fire_in) idx++;
        end
        if16.in_valid  = 1'b0;
        if16.out_ready = 1'b1;
        #1;
        chk("bp_count",       32'(oidx),           32'd4);
        chk("bp_dups",        32'(dups),           32'd0);
        chk("bp_drained",     32'(if16.out_valid), 32'd0);

        // ---------------- accumulate chain ----------------
        acc_clr = 1'b1;
        step();
        acc_clr = 1'b0;
        #1;
        chk("acc_clr", 32'(acc16), 32'd0);

        idx = 0; oidx = 0; prev_fire = 1'b0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if16.in_valid = (idx < 3);
            if16.op       = 2'b10;
            if16.a        = 16'hDEAD;
            if16.b        = 16'h4000;
            #1;
            if (prev_fire && if16.in_valid)
                chk("acc_hazard_ready", 32'(if16.in_ready), 32'd0);
            fire_in  = if16.in_valid & if16.in_ready;
            fire_out = if16.out_valid & if16.out_ready;
            if (fire_out && oidx < 3) begin
                chk("acc_sum", 32'(if16.sum),      32'(ac_exp[oidx]));
                chk("acc_pos", 32'(if16.pos_ovfl), 32'(ac_pos[oidx]));
                chk("acc_reg", 32'(acc16),         32'(ac_exp[oidx]));
                $display("txn acc_out idx=%0d sum=0x%04h acc=0x%04h pos=%0b",
                         oidx, if16.sum, acc16, if16.pos_ovfl);
            end
            if (fire_out) oidx++;
            prev_fire = fire_in;
            step();
            if (fire_in) idx++;
        end
        if16.in_valid = 1'b0;
        #1;
        chk("acc_count",      32'(oidx),         32'd3);
        chk("acc_sticky_pos", 32'(sticky_pos16), 32'd1);

        sticky_clr = 1'b1;
        step();
        sticky_clr = 1'b0;

        // ---------------- simultaneous clear events ----------------
        // acc is 0x7FFF; acc+1 saturates. Clears land on the result-write edge.
        if16.in_valid = 1'b1;
        if16.op = 2'b10;
        if16.a  = 16'h0000;
        if16.b  = 16'h0001;
        #1;
        chk("sim_in_ready", 32'(if16.in_ready), 32'd1);
        step();
        if16.in_valid = 1'b0;
        acc_clr    = 1'b1;
        sticky_clr = 1'b1;
        step();
        acc_clr    = 1'b0;
        sticky_clr = 1'b0;
        #1;
        chk("sim_valid",      32'(if16.out_valid), 32'd1);
        chk("sim_sum_oldacc", 32'(if16.sum),       32'h7FFF);
        chk("sim_pos",        32'(if16.pos_ovfl),  32'd1);
        chk("sim_acc_clr",    32'(acc16),          32'd0);
        chk("sim_sticky_pos", 32'(sticky_pos16),   32'd1);
        chk("sim_sticky_neg", 32'(sticky_neg16),   32'd0);
        $display("txn simultaneous sum=0x%04h acc=0x%04h sticky_pos=%0b",
                 if16.sum, acc16, sticky_pos16);
        step();

        // ---------------- reset mid-flight ----------------
        if16.in_valid = 1'b1;
        if16.op = 2'b10;
        if16.b  = 16'h0100;
        step();
        if16.op = 2'b00;
        if16.a  = 16'h8000;
        if16.b  = 16'hFFFF;
        #1;
        chk("mf_second_ready", 32'(if16.in_ready), 32'd1);
        step();
        if16.in_valid = 1'b0;
        #1;
        chk("mf_pre_valid", 32'(if16.out_valid), 32'd1);
        chk("mf_pre_acc",   32'(acc16),          32'h0100);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("mf_out_valid",  32'(if16.out_valid), 32'd0);
        chk("mf_acc",        32'(acc16),          32'd0);
        chk("mf_sticky_pos", 32'(sticky_pos16),   32'd0);
        chk("mf_sticky_neg", 32'(sticky_neg16),   32'd0);
        chk("mf_in_ready",   32'(if16.in_ready),  32'd1);
        chk("mf_zero",       32'(if16.zero),      32'd1);
        step();
        #1;
        chk("mf_discarded", 32'(if16.out_valid), 32'd0);
        $display("txn reset_midflight out_valid=%0b acc=0x%04h", if16.out_valid, acc16);

        // ---------------- WIDTH=8 instance ----------------
        if8.in_valid = 1'b1;
        if8.op = 2'b00;
        if8.a  = 8'h7F;
        if8.b  = 8'h01;
        #1;
        chk("w8_in_ready", 32'(if8.in_ready), 32'd1);
        step();
        if8.in_valid = 1'b0;
        step();
        #1;
        chk("w8_pos_valid", 32'(if8.out_valid), 32'd1);
        chk("w8_pos_sum",   32'(if8.sum),       32'h7F);
        chk("w8_pos_flag",  32'(if8.pos_ovfl),  32'd1);
        chk("w8_sticky",    32'(sticky_pos8),   32'd1);
        $display("txn w8 a=0x7F b=0x01 sum=0x%02h pos=%0b", if8.sum, if8.pos_ovfl);
        step();

        if8.in_valid = 1'b1;
        if8.a = 8'h80;
        if8.b = 8'hFF;
        step();
        if8.in_valid = 1'b0;
        step();
        #1;
        chk("w8_neg_sum",  32'(if8.sum),      32'h80);
        chk("w8_neg_flag", 32'(if8.neg_ovfl), 32'd1);
        $display("txn w8 a=0x80 b=0xFF sum=0x%02h neg=%0b", if8.sum, if8.neg_ovfl);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
